ram_loader: RTL and testbench

- Bus-master writer for the 16x8 program RAM and its MAR.
- Accepts a byte stream over a valid/ready handshake, e.g. from the serial receiver or a switch panel.
- For each byte it sequences a MAR-load cycle (mi) and a RAM-write cycle (ri) on the shared 8-bit bus, then reads the byte back from ram_value to verify it.
- Holds the CPU halted while it owns the bus.

---
 rtl/ram_loader_pkg.sv | 19 +
 rtl/ram_loader_if.sv | 38 +++
 rtl/ram_loader.sv | 107 ++++++++++
 tb/tb_ram_loader.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_loader_pkg.sv
// Shared constants and FSM state type for the program-RAM loader.
// Widths are shared with the RAM/MAR block.
package ram_loader_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BYTE,
    SET_ADDR,
    WRITE,
    VERIFY,
    DONE,
    ERR
  } state_e;

endpackage

// File: rtl/ram_loader_if.sv
// Byte-stream handshake plus shared-bus strobes between
// the loader (master) and the RAM/MAR side (slave).
interface ram_loader_if #(
  parameter int DATA_W = ram_loader_pkg::DATA_W
);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] bus_out;
  logic              bus_oe;
  logic              mi;
  logic              ri;
  logic [DATA_W-1:0] ram_value;

  modport master (
    input  in_data,
    input  in_valid,
    input  ram_value,
    output in_ready,
    output bus_out,
    output bus_oe,
    output mi,
    output ri
  );

  modport slave (
    output in_data,
    output in_valid,
    output ram_value,
    input  in_ready,
    input  bus_out,
    input  bus_oe,
    input  mi,
    input  ri
  );

endinterface

// File: rtl/ram_loader.sv
// Loads DEPTH bytes into program RAM via MAR/RAM strobes,
// verifying each byte by reading it back.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int DATA_W = ram_loader_pkg::DATA_W,
  parameter int ADDR_W = ram_loader_pkg::ADDR_W,
  parameter int DEPTH  = ram_loader_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  ram_loader_if.master      b,
  output logic              cpu_halt,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              done_q;
  logic              error_q;
  logic [ADDR_W-1:0] err_addr_q;

  // Sequencer: accept byte, load MAR, write RAM, verify.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_addr_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= WAIT_BYTE;
            addr_q     <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_addr_q <= '0;
          end
        end
        WAIT_BYTE: begin
          if (b.in_valid) begin
            data_q  <= b.in_data;
            state_q <= SET_ADDR;
          end
        end
        SET_ADDR: state_q <= WRITE;
        WRITE:    state_q <= VERIFY;
        VERIFY: begin
          if (b.ram_value != data_q) begin
            state_q    <= ERR;
            error_q    <= 1'b1;
            err_addr_q <= addr_q;
          end else if (addr_q == LAST) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            addr_q  <= addr_q + 1'b1;
            state_q <= WAIT_BYTE;
          end
        end
        DONE:    state_q <= IDLE;
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Moore decode of bus strobes from the state register.
  always_comb begin
    b.in_ready = 1'b0;
    b.bus_out  = '0;
    b.bus_oe   = 1'b0;
    b.mi       = 1'b0;
    b.ri       = 1'b0;
    unique case (state_q)
      WAIT_BYTE: b.in_ready = 1'b1;
      SET_ADDR: begin
        b.bus_oe  = 1'b1;
        b.mi      = 1'b1;
        b.bus_out = DATA_W'(addr_q);
      end
      WRITE: begin
        b.bus_oe  = 1'b1;
        b.ri      = 1'b1;
        b.bus_out = data_q;
      end
      default: ;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign cpu_halt = (state_q != IDLE);
  assign done     = done_q;
  assign error    = error_q;
  assign err_addr = err_addr_q;

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader with a behavioural RAM/MAR block
// and a write scoreboard.
module tb_ram_loader;
  import ram_loader_pkg::*;

  logic              clk = 1'b0;
  logic              clr;
  logic              start;
  logic              cpu_halt;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W-1:0] err_addr;

  ram_loader_if bus_if ();

  ram_loader dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .b        (bus_if.master),
    .cpu_halt (cpu_halt),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .err_addr (err_addr)
  );

  always #5 clk = ~clk;

  // RAM/MAR model
  logic [DATA_W-1:0] ram [DEPTH] = '{default: 8'hFF};
  logic [ADDR_W-1:0] mar_q;
  logic              fault_en;

  always @(posedge clk or posedge clr)
    if (clr) mar_q <= '0;
    else if (bus_if.mi) mar_q <= bus_if.bus_out[ADDR_W-1:0];

  always @(posedge clk)
    if (bus_if.ri) ram[mar_q] <= bus_if.bus_out;

  assign bus_if.ram_value =
    (fault_en && mar_q == 4'd5) ? '0 : ram[mar_q];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } exp_t;

  exp_t              sbq [$];
  exp_t              e_mon;
  logic [ADDR_W-1:0] exp_addr;
  int                mi_cnt  = 0;
  int                ri_cnt  = 0;
  int                overlap = 0;
  int                leak    = 0;
  int                gap_bad = 0;
  int                last_acc;

  // Monitor: strobe rules and scoreboard pop on each write
  always @(negedge clk) begin
    if (!clr) begin
      if (bus_if.mi && bus_if.ri) overlap++;
      if (!bus_if.bus_oe && bus_if.bus_out != '0) leak++;
      if (bus_if.mi) mi_cnt++;
      if (bus_if.ri) begin
        ri_cnt++;
        if (sbq.size() == 0) begin
          chk("sb_empty", 32'd1, 32'd0);
        end else begin
          e_mon = sbq.pop_front();
          chk("wr_addr", 32'(mar_q), 32'(e_mon.a));
          chk("wr_data", 32'(bus_if.bus_out), 32'(e_mon.d));
        end
      end
    end
  end

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_addr = '0;
  endtask

  task automatic send(input logic [7:0] d, input int gap);
    int n = 0;
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = d;
    while (!bus_if.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus_if.in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      bus_if.in_valid = 1'b0;
      return;
    end
    sbq.push_back('{a: exp_addr, d: d});
    exp_addr = exp_addr + 1'b1;
    last_acc = cyc + 1;
    @(negedge clk);
    if (gap > 0) begin
      bus_if.in_valid = 1'b0;
      n = 0;
      while (!bus_if.in_ready && !done && n < 10) begin
        @(negedge clk);
        n++;
      end
      if (!done) begin
        repeat (gap) begin
          if (!bus_if.in_ready) gap_bad++;
          if (bus_if.mi || bus_if.ri) gap_bad++;
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic ram_check(input string tag,
                           input logic [7:0] base);
    int bad = 0;
    for (int i = 0; i < DEPTH; i++)
      if (ram[i] != base + 8'(i)) bad++;
    chk(tag, 32'(bad), 32'd0);
  endtask

  logic [7:0] snap [DEPTH];
  int         t0;
  int         n;
  int         bad;

  initial begin
    clr = 1'b1;
    start = 1'b0;
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = '0;
    fault_en = 1'b0;
    exp_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_flags",
        32'({busy, cpu_halt, done, error, bus_if.in_ready}), 32'd0);
    chk("rst_bus",
        32'({bus_if.bus_oe, bus_if.mi, bus_if.ri}), 32'd0);
    chk("rst_bus_out", 32'(bus_if.bus_out), 32'd0);
    chk("rst_err_addr", 32'(err_addr), 32'd0);

    // start coincident with clr is dropped
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    clr = 1'b0;
    @(negedge clk);
    chk("start_in_clr", 32'(busy), 32'd0);

    // back-to-back load
    mi_cnt = 0;
    ri_cnt = 0;
    do_start();
    for (int i = 0; i < DEPTH; i++) begin
      send(8'h10 + 8'(i), 0);
      if (i == 0) t0 = last_acc;
    end
    bus_if.in_valid = 1'b0;
    wait_done();
    chk("b2b_done", 32'(done), 32'd1);
    chk("b2b_done_lat", 32'(cyc - t0), 32'd63);
    chk("b2b_error", 32'(error), 32'd0);
    @(negedge clk);
    chk("b2b_idle", 32'({busy, cpu_halt}), 32'd0);
    chk("b2b_done_sticky", 32'(done), 32'd1);
    ram_check("b2b_ram", 8'h10);
    chk("b2b_mi_cnt", 32'(mi_cnt), 32'd16);
    chk("b2b_ri_cnt", 32'(ri_cnt), 32'd16);

    // gapped stream
    do_start();
    chk("start_clears_done", 32'(done), 32'd0);
    for (int i = 0; i < DEPTH; i++) send(8'h20 + 8'(i), 3);
    wait_done();
    chk("gap_done", 32'(done), 32'd1);
    chk("gap_wait", 32'(gap_bad), 32'd0);
    ram_check("gap_ram", 8'h20);
    @(negedge clk);

    // verify fault at address 5
    for (int i = 0; i < DEPTH; i++) snap[i] = ram[i];
    fault_en = 1'b1;
    do_start();
    for (int i = 0; i < 6; i++) send(8'hA0 + 8'(i), 0);
    bus_if.in_valid = 1'b0;
    n = 0;
    while (!error && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("flt_error", 32'(error), 32'd1);
    @(negedge clk);
    chk("flt_err_addr", 32'(err_addr), 32'd5);
    chk("flt_done", 32'(done), 32'd0);
    chk("flt_idle", 32'(busy), 32'd0);
    chk("flt_error_sticky", 32'(error), 32'd1);
    bad = 0;
    for (int i = 6; i < DEPTH; i++) if (ram[i] != snap[i]) bad++;
    chk("flt_untouched", 32'(bad), 32'd0);
    chk("flt_ram4", 32'(ram[4]), 32'hA4);
    fault_en = 1'b0;

    // in_valid in IDLE and start mid-load are ignored
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 8'hEE;
    repeat (2) @(negedge clk);
    chk("idle_ready", 32'(bus_if.in_ready), 32'd0);
    chk("idle_no_push", 32'(sbq.size()), 32'd0);
    bus_if.in_valid = 1'b0;
    mi_cnt = 0;
    ri_cnt = 0;
    do_start();
    chk("start_clears_err",
        32'({error, 4'(err_addr)}), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 7) start = 1'b1;
      send(8'h30 + 8'(i), 0);
      start = 1'b0;
    end
    bus_if.in_valid = 1'b0;
    wait_done();
    chk("mid_done", 32'(done), 32'd1);
    ram_check("mid_ram", 8'h30);
    chk("mid_mi_cnt", 32'(mi_cnt), 32'd16);
    chk("mid_ri_cnt", 32'(ri_cnt), 32'd16);
    @(negedge clk);

    // async clr during WRITE at address 9
    do_start();
    for (int i = 0; i < 10; i++) send(8'h40 + 8'(i), 0);
    bus_if.in_valid = 1'b0;
    @(negedge clk);
    chk("clr_in_write", 32'(bus_if.ri), 32'd1);
    #1 clr = 1'b1;
    #1;
    chk("clr_outs",
        32'({busy, cpu_halt, bus_if.bus_oe, bus_if.mi,
             bus_if.ri, bus_if.in_ready, done, error}), 32'd0);
    chk("clr_bus_out", 32'(bus_if.bus_out), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    chk("clr_partial9", 32'(ram[9]), 32'h39);
    chk("clr_partial8", 32'(ram[8]), 32'h48);
    do_start();
    for (int i = 0; i < DEPTH; i++) send(8'h50 + 8'(i), 0);
    bus_if.in_valid = 1'b0;
    wait_done();
    chk("reload_done", 32'(done), 32'd1);
    ram_check("reload_ram", 8'h50);
    @(negedge clk);

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    chk("mi_ri_overlap", 32'(overlap), 32'd0);
    chk("bus_leak", 32'(leak), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
